uart_tx_scheduler: RTL and testbench

//  Upstream stage of the UART link. Turns game-event levels into single-byte message writes for the UART TX FIFO.

---
 rtl/uart_tx_scheduler.sv | 148 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Turns game-event levels into single-byte UART TX FIFO writes: edge capture,
// sticky priority arbitration, write pacing and periodic READY resend.
module uart_tx_scheduler #(
  parameter logic [7:0] MSG_GAME_OVER = 8'h47,
  parameter logic [7:0] MSG_HIT       = 8'h48,
  parameter logic [7:0] MSG_READY     = 8'h52,
  parameter int         GAP_CYCLES    = 16,
  parameter int         RESEND_CYCLES = 6_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       multiplayer,
  input  logic       game_over,
  input  logic       player_hit,
  input  logic       player_ready,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic [2:0] pending,
  output logic       link_done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RESEND_LAST = RW'(RESEND_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    in_q;
  logic [2:0]    in_prev;
  logic [2:0]    rise;
  logic [2:0]    grant;
  logic [2:0]    set_req;
  logic [2:0]    pending_nxt;
  logic [7:0]    wr_byte;
  logic          write_en;
  logic          resend_run;
  logic          resend_fire;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] resend_cnt;
  logic [RW-1:0] resend_nxt;

  // Bit order everywhere is {go, hit, rdy}.
  assign rise = in_q & ~in_prev;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    grant       = 3'b000;
    wr_byte     = MSG_READY;
    if (pending[2]) begin
      grant   = 3'b100;
      wr_byte = MSG_GAME_OVER;
    end else if (pending[1]) begin
      grant   = 3'b010;
      wr_byte = MSG_HIT;
    end else if (pending[0]) begin
      grant   = 3'b001;
    end

    write_en    = multiplayer && (state == IDLE) && (pending != 3'b000) && !tx_full;
    resend_run  = multiplayer && in_q[0] && (state != DONE);
    resend_nxt  = (resend_cnt == RESEND_LAST) ? '0 : resend_cnt + RW'(1);
    // A READY write in the same cycle restarts the period instead of re-arming it.
    resend_fire = resend_run && (resend_nxt == RESEND_LAST) && !(write_en && grant[0]);

    set_req     = (multiplayer && (state != DONE)) ? (rise | {2'b00, resend_fire}) : 3'b000;
    pending_nxt = (pending & ~(write_en ? grant : 3'b000)) | set_req;
    if (!multiplayer || (state == DONE)) pending_nxt = 3'b000;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q    <= 3'b000;
      in_prev <= 3'b000;
    end else begin
      in_q    <= {game_over, player_hit, player_ready};
      in_prev <= in_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resend_cnt <= '0;
    end else if (!resend_run || (write_en && grant[0])) begin
      resend_cnt <= '0;
    end else begin
      resend_cnt <= resend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      wr_uart   <= 1'b0;
      w_data    <= 8'h00;
      pending   <= 3'b000;
      link_done <= 1'b0;
    end else if (!multiplayer) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      wr_uart   <= 1'b0;
      pending   <= 3'b000;
      link_done <= 1'b0;
    end else begin
      pending <= pending_nxt;
      wr_uart <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (write_en) begin
            wr_uart <= 1'b1;
            w_data  <= wr_byte;
            if (grant[2]) begin
              state     <= DONE;
              link_done <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        DONE: begin
          if (!game_over) begin
            state     <= IDLE;
            link_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected bytes are queued when stimulus
// is driven and popped by a write monitor that also polices spacing and tx_full.
module tb_uart_tx_scheduler;

  localparam int GAP    = 8;
  localparam int RESEND = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       multiplayer;
  logic       game_over;
  logic       player_hit;
  logic       player_ready;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [2:0] pending;
  logic       link_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         wr_total = 0;
  int         last_wr_cyc;
  int         prev_wr_cyc;
  bit         last_wr_valid = 1'b0;
  logic       full_at_edge = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx_scheduler #(
    .MSG_GAME_OVER(8'h47),
    .MSG_HIT      (8'h48),
    .MSG_READY    (8'h52),
    .GAP_CYCLES   (GAP),
    .RESEND_CYCLES(RESEND)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .multiplayer (multiplayer),
    .game_over   (game_over),
    .player_hit  (player_hit),
    .player_ready(player_ready),
    .tx_full     (tx_full),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .pending     (pending),
    .link_done   (link_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    full_at_edge <= tx_full;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      last_wr_valid = 1'b0;
    end else if (wr_uart) begin
      wr_total++;
      check("no_wr_while_full", int'(full_at_edge), 0);
      if (last_wr_valid) check("wr_spacing_ok", int'((cyc - last_wr_cyc) >= GAP + 1), 1);
      prev_wr_cyc   = last_wr_cyc;
      last_wr_cyc   = cyc;
      last_wr_valid = 1'b1;
      check("sb_has_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("w_data", int'(w_data), int'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_write(input string tag, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (wr_uart) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, int'(seen), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_r;
    int base;

    rst          = 1'b0;
    multiplayer  = 1'b1;
    game_over    = 1'b0;
    player_hit   = 1'b0;
    player_ready = 1'b0;
    tx_full      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_uart", int'(wr_uart), 0);
    check("rst_w_data", int'(w_data), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_link_done", int'(link_done), 0);
    tick();
    rst = 1'b1;
    repeat (5) tick();

    // Single hit: strobe exactly three edges after the input rises.
    player_hit = 1'b1;
    exp_q.push_back(8'h48);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t1_wr_k%0d", k), int'(wr_uart), int'(k == 3));
      if (k == 2) check("t1_pending_set", int'(pending), 3'b010);
      if (k == 3) begin
        check("t1_w_data", int'(w_data), 8'h48);
        check("t1_pending_clr", int'(pending), 0);
      end
    end
    tick();
    player_hit = 1'b0;
    repeat (20) @(negedge clk);
    check("t1_sb_drained", exp_q.size(), 0);

    // Game over and hit together: 'G' wins, hit is dropped in DONE.
    tick();
    game_over  = 1'b1;
    player_hit = 1'b1;
    exp_q.push_back(8'h47);
    wait_write("t2_go_written", 10);
    check("t2_link_done_set", int'(link_done), 1);
    repeat (40) @(negedge clk);
    check("t2_pending_done", int'(pending), 0);
    check("t2_link_done_hold", int'(link_done), 1);
    tick();
    game_over  = 1'b0;
    player_hit = 1'b0;
    @(negedge clk);
    check("t2_link_done_k0", int'(link_done), 1);
    @(negedge clk);
    check("t2_link_done_k1", int'(link_done), 0);
    repeat (30) @(negedge clk);
    check("t2_sb_drained", exp_q.size(), 0);

    // READY held off by a full FIFO, written one edge after it drains.
    tick();
    tx_full      = 1'b1;
    player_ready = 1'b1;
    repeat (50) @(negedge clk);
    check("t3_pending_rdy", int'(pending), 3'b001);
    tick();
    tx_full = 1'b0;
    exp_q.push_back(8'h52);
    @(negedge clk);
    check("t3_wr_k0", int'(wr_uart), 0);
    @(negedge clk);
    check("t3_wr_k1", int'(wr_uart), 1);
    last_r = cyc;

    // READY kept high: resend every RESEND clocks, silenced by multiplayer=0.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h52);
      wait_write($sformatf("t4_resend_seen%0d", i), 150);
      check($sformatf("t4_period%0d", i), cyc - last_r, RESEND);
      last_r = cyc;
    end
    tick();
    multiplayer = 1'b0;
    base = wr_total;
    repeat (250) @(negedge clk);
    check("t4_silent_writes", wr_total - base, 0);
    check("t4_silent_pending", int'(pending), 0);
    tick();
    player_ready = 1'b0;
    tick();
    multiplayer = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_sb_drained", exp_q.size(), 0);

    // Five hit pulses inside one gap window coalesce into two writes.
    base = wr_total;
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h48);
    for (int p = 0; p < 5; p++) begin
      tick();
      player_hit = 1'b1;
      tick();
      player_hit = 1'b0;
    end
    repeat (40) @(negedge clk);
    check("t5_write_count", wr_total - base, 2);
    check("t5_spacing", last_wr_cyc - prev_wr_cyc, GAP + 1);
    check("t5_sb_drained", exp_q.size(), 0);

    // Reset during GAP with hit and rdy pending.
    tick();
    player_hit = 1'b1;
    exp_q.push_back(8'h48);
    wait_write("t6_hit_written", 10);
    tick();
    player_hit   = 1'b0;
    player_ready = 1'b1;
    tick();
    player_hit = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_pending_011", int'(pending), 3'b011);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_wr_uart", int'(wr_uart), 0);
    check("t6_rst_w_data", int'(w_data), 0);
    check("t6_rst_pending", int'(pending), 0);
    check("t6_rst_link_done", int'(link_done), 0);
    player_hit   = 1'b0;
    player_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_no_write_after_rst", int'(pending), 0);
    check("t6_sb_drained", exp_q.size(), 0);
    tick();
    player_ready = 1'b1;
    exp_q.push_back(8'h52);
    wait_write("t6_new_rise_written", 10);

    // An input already high when reset releases counts as a rise.
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.push_back(8'h52);
    wait_write("t6_high_at_release", 10);
    tick();
    player_ready = 1'b0;
    repeat (20) @(negedge clk);
    check("final_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
